// File: rtl/ctrl_decode.sv
// Multicycle ARM main control: sequencing FSM plus main, ALU and PC decoders.
// All outputs are combinational from the state register and the decode inputs.
module ctrl_decode (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Undef,
  output logic [3:0] State
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  logic [3:0] state_q;
  logic [3:0] state_d;

  logic [3:0] cmd;
  logic       dp_ok;
  logic       no_write;
  logic       arith;
  logic [1:0] cmd_ctl;
  logic       alu_op;
  logic       branch;
  logic       reg_w_raw;
  logic       bad_instr;

  assign cmd   = Funct[4:1];
  assign State = state_q;

  // Data-processing command decode: support, ALU function, write suppression
  always_comb begin
    dp_ok    = 1'b1;
    no_write = 1'b0;
    arith    = 1'b0;
    cmd_ctl  = 2'b00;
    case (cmd)
      4'b0100: begin cmd_ctl = 2'b00; arith = 1'b1; end
      4'b0010: begin cmd_ctl = 2'b01; arith = 1'b1; end
      4'b0000: cmd_ctl = 2'b10;
      4'b1100: cmd_ctl = 2'b11;
      4'b1010: begin
        cmd_ctl  = 2'b01;
        arith    = 1'b1;
        no_write = 1'b1;
        dp_ok    = Funct[0];
      end
      default: dp_ok = 1'b0;
    endcase
  end

  assign bad_instr = (Op == 2'b11) | ((Op == 2'b00) & ~dp_ok);

  // Next-state sequencing
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        if (bad_instr)          state_d = S_FETCH;
        else if (Op == 2'b01)   state_d = S_MEMADR;
        else if (Op == 2'b10)   state_d = S_BRANCH;
        else if (Funct[5])      state_d = S_EXECUTEI;
        else                    state_d = S_EXECUTER;
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Moore control outputs per state
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    NextPC    = 1'b0;
    reg_w_raw = 1'b0;
    MemW      = 1'b0;
    alu_op    = 1'b0;
    branch    = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR:   ALUSrcB = 2'b01;
      S_MEMRD:    AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w_raw = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECUTER: alu_op = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      S_ALUWB:    reg_w_raw = ~no_write;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decode, immediate/register selects and PC write logic
  always_comb begin
    ALUControl = alu_op ? cmd_ctl : 2'b00;
    FlagW      = alu_op ? {Funct[0], Funct[0] & arith} : 2'b00;
    ImmSrc     = Op;
    RegSrc     = {Op == 2'b01, Op == 2'b10};
    RegW       = reg_w_raw;
    PCS        = ((Rd == 4'hf) & reg_w_raw) | branch;
    Undef      = (state_q == S_DECODE) & bad_instr;
  end

endmodule

// File: tb/tb_ctrl_decode.sv
// Self-checking bench for ctrl_decode: directed and random instructions
// compared cycle by cycle against an instruction-level reference model.
module tb_ctrl_decode;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [1:0] alu_control;
    logic [1:0] flag_w;
    logic       pcs;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       undef;
    logic [3:0] state;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite, AdrSrc, ALUSrcA, PCS, NextPC, RegW, MemW, Undef;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW;
  logic [3:0] State;

  ctl_t obs;
  ctl_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  ctrl_decode dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .ALUControl(ALUControl), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .Undef(Undef), .State(State)
  );

  always #5 clk = ~clk;

  assign obs = '{IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
                 RegSrc, ALUControl, FlagW, PCS, NextPC, RegW, MemW,
                 Undef, State};

  task automatic chk(input string tag, input ctl_t o, input ctl_t e);
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
               tag, o, o.state, e, e.state);
    end
  endtask

  // Expected per-cycle controls of one instruction, from its mnemonic class
  task automatic build(input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] rd);
    ctl_t base, c;
    logic [3:0] cm;
    bit   bad, is_cmp;
    cm     = f[4:1];
    is_cmp = (cm == 4'd10);
    bad    = (op == 2'b11) ||
             (op == 2'b00 && !(cm == 4'd4 || cm == 4'd2 || cm == 4'd0 ||
                               cm == 4'd12 || (is_cmp && f[0])));
    exp_q.delete();
    base = '0;
    base.imm_src = op;
    base.reg_src = {op == 2'b01, op == 2'b10};
    c = base;
    c.ir_write = 1; c.next_pc = 1; c.alu_src_a = 1;
    c.alu_src_b = 2; c.result_src = 2; c.state = 0;
    exp_q.push_back(c);
    c = base;
    c.alu_src_a = 1; c.alu_src_b = 2; c.result_src = 2;
    c.state = 1; c.undef = bad;
    exp_q.push_back(c);
    if (bad) return;
    if (op == 2'b01) begin
      c = base; c.state = 2; c.alu_src_b = 1;
      exp_q.push_back(c);
      if (f[0]) begin
        c = base; c.state = 3; c.adr_src = 1;
        exp_q.push_back(c);
        c = base; c.state = 4; c.result_src = 1; c.reg_w = 1;
        c.pcs = (rd == 4'd15);
        exp_q.push_back(c);
      end else begin
        c = base; c.state = 5; c.adr_src = 1; c.mem_w = 1;
        exp_q.push_back(c);
      end
    end else if (op == 2'b00) begin
      c = base;
      c.state = f[5] ? 4'd7 : 4'd6;
      c.alu_src_b = f[5] ? 2'd1 : 2'd0;
      case (cm)
        4'd4:    c.alu_control = 2'd0;
        4'd2:    c.alu_control = 2'd1;
        4'd0:    c.alu_control = 2'd2;
        4'd12:   c.alu_control = 2'd3;
        default: c.alu_control = 2'd1;
      endcase
      c.flag_w = {f[0], f[0] && (cm == 4'd4 || cm == 4'd2 || is_cmp)};
      exp_q.push_back(c);
      c = base; c.state = 8; c.reg_w = !is_cmp;
      c.pcs = !is_cmp && (rd == 4'd15);
      exp_q.push_back(c);
    end else begin
      c = base; c.state = 9; c.alu_src_b = 1;
      c.result_src = 2; c.pcs = 1;
      exp_q.push_back(c);
    end
  endtask

  // Called mid-cycle while the DUT sits in FETCH
  task automatic run_instr(input string nm, input logic [1:0] op,
                           input logic [5:0] f, input logic [3:0] rd);
    build(op, f, rd);
    Op = op; Funct = f; Rd = rd;
    foreach (exp_q[i]) begin
      #2;
      chk($sformatf("%s c%0d", nm, i), obs, exp_q[i]);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ctl_t fetch_e;
    reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
    build(2'b00, 6'd0, 4'd0);
    fetch_e = exp_q[0];
    #2 chk("reset t0", obs, fetch_e);
    repeat (3) begin
      @(posedge clk); #2;
      chk("reset held", obs, fetch_e);
    end
    reset = 1'b0;

    run_instr("add_r", 2'b00, 6'b001000, 4'd1);
    run_instr("add_i", 2'b00, 6'b101000, 4'd1);
    run_instr("ldr",   2'b01, 6'b011001, 4'd3);
    run_instr("str",   2'b01, 6'b011000, 4'd3);
    run_instr("subs",  2'b00, 6'b000101, 4'd2);
    run_instr("cmp",   2'b00, 6'b010101, 4'd0);
    run_instr("orr",   2'b00, 6'b111000, 4'd4);
    run_instr("and_s", 2'b00, 6'b100001, 4'd5);
    run_instr("b",     2'b10, 6'b100000, 4'd0);
    run_instr("add15", 2'b00, 6'b101000, 4'd15);
    run_instr("ldr15", 2'b01, 6'b011001, 4'd15);
    run_instr("undef", 2'b11, 6'b000000, 4'd0);
    run_instr("cmd1",  2'b00, 6'b000010, 4'd1);
    run_instr("cmp_s0", 2'b00, 6'b010100, 4'd1);

    // Asynchronous reset landing in the middle of MEMWR
    build(2'b01, 6'b011000, 4'd6);
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd6;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #1 chk("pre-abort memwr", obs, exp_q[3]);
    reset = 1'b1;
    #1 chk("async abort", obs, exp_q[0]);
    @(posedge clk); #2;
    chk("abort held", obs, exp_q[0]);
    reset = 1'b0;
    run_instr("post-abort", 2'b00, 6'b001001, 4'd7);

    for (int n = 0; n < 200; n++) begin
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] rd;
      op = 2'($urandom_range(3, 0));
      f  = 6'($urandom);
      rd = 4'($urandom);
      run_instr($sformatf("rnd%0d", n), op, f, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
